// File: rtl/accumulator_64b_pp_pkg.sv
// rtl/accumulator_64b_pp_pkg.sv - shared state type and default widths for the group accumulator
package accumulator_pkg;

  localparam int DefDw = 64;
  localparam int DefGw = 16;
  localparam int DefLw = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } accState_t;

endpackage

// File: rtl/accumulator_64b_pp_if.sv
// rtl/accumulator_64b_pp_if.sv - product-in / group-sum-out handshake bundle
interface accumulator_64b_pp_if
  import accumulator_pkg::*;
#(
  parameter int DW = DefDw,
  parameter int GW = DefGw,
  parameter int LW = DefLw
);
  logic               iValid;
  logic [DW-1:0]      iData;
  logic [LW-1:0]      iLen;
  logic               iReady;
  logic               oReady;
  logic               oValid;
  logic [DW+GW-1:0]   oData;
  logic               oOvf;

  modport slave (
    input  iValid, iData, iLen, iReady,
    output oReady, oValid, oData, oOvf
  );

  modport master (
    output iValid, iData, iLen, iReady,
    input  oReady, oValid, oData, oOvf
  );
endinterface

// File: rtl/accumulator_64b_pp_adder_sat.sv
// rtl/accumulator_64b_pp_adder_sat.sv - unsigned DW+GW adder; ACCUMULATOR_SAT_EN clamps on carry-out
module adder_sat
  import accumulator_pkg::*;
#(
  parameter int DW = DefDw,
  parameter int GW = DefGw
) (
  input  logic [DW+GW-1:0] iA,
  input  logic [DW-1:0]    iB,
  output logic [DW+GW-1:0] oSum,
  output logic             oOvf
);
  localparam int W = DW + GW;

  logic [W-1:0] bExt;
  assign bExt = W'(iB);

`ifdef ACCUMULATOR_SAT_EN
  logic [W:0] wide;
  assign wide = {1'b0, iA} + {1'b0, bExt};
  assign oOvf = wide[W];
  // An all-ones accumulator overflows again on any non-zero addend, so saturation sticks.
  assign oSum = wide[W] ? {W{1'b1}} : wide[W-1:0];
`else
  assign oSum = iA + bExt;
  assign oOvf = 1'b0;
`endif
endmodule

// File: rtl/accumulator_64b_pp.sv
// rtl/accumulator_64b_pp.sv - groups iLen products into one sum; ACCUMULATOR_SAT_EN enables saturation
module accumulator_64b_pp
  import accumulator_pkg::*;
#(
  parameter int DW = DefDw,
  parameter int GW = DefGw,
  parameter int LW = DefLw
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEn,
  input  logic                 iClr,
  accumulator_64b_pp_if.slave  bus
);
  localparam int W = DW + GW;

  accState_t     state, stateNext;
  logic [W-1:0]  acc, accNext, addSum;
  logic [LW-1:0] cnt, cntNext, len, lenNext, lenFirst;
  logic          ovf, ovfNext, addOvf, beat;

  adder_sat #(.DW(DW), .GW(GW)) uAdd (
    .iA   (acc),
    .iB   (bus.iData),
    .oSum (addSum),
    .oOvf (addOvf)
  );

  assign bus.oReady = (state != HOLD);
  assign bus.oValid = (state == HOLD);
  assign bus.oData  = acc;
  assign bus.oOvf   = ovf;

  assign beat     = bus.iValid && bus.oReady && iEn && !iClr;
  assign lenFirst = (bus.iLen == '0) ? LW'(1) : bus.iLen;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= stateNext;
      acc   <= accNext;
      cnt   <= cntNext;
      len   <= lenNext;
      ovf   <= ovfNext;
    end
  end

  always_comb begin
    stateNext = state;
    accNext   = acc;
    cntNext   = cnt;
    lenNext   = len;
    ovfNext   = ovf;
    if (iClr) begin
      stateNext = IDLE;
      accNext   = '0;
      cntNext   = '0;
      lenNext   = '0;
      ovfNext   = 1'b0;
    end else if (iEn) begin
      unique case (state)
        IDLE: begin
          if (beat) begin
            accNext   = W'(bus.iData);
            cntNext   = LW'(1);
            lenNext   = lenFirst;
            ovfNext   = 1'b0;
            stateNext = (lenFirst == LW'(1)) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (beat) begin
            accNext = addSum;
            cntNext = cnt + LW'(1);
            ovfNext = ovf | addOvf;
            if (cnt + LW'(1) == len) stateNext = HOLD;
          end
        end
        HOLD: begin
          // Result is held until downstream takes it; the freed cycle is the group bubble.
          if (bus.iReady) begin
            stateNext = IDLE;
            ovfNext   = 1'b0;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accumulator_64b_pp.sv
// tb/tb_accumulator_64b_pp.sv - directed vectors for accumulator_64b_pp (expectations follow ACCUMULATOR_SAT_EN)
module tb_accumulator_64b_pp;
  import accumulator_pkg::*;

`ifdef ACCUMULATOR_SAT_EN
  localparam logic [63:0] OvfSum  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic        OvfFlag = 1'b1;
`else
  localparam logic [63:0] OvfSum  = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic        OvfFlag = 1'b0;
`endif

  logic iClk = 1'b0;
  logic iRst, iEn, iClr;
  int   nVec = 0;
  int   nErr = 0;

  always #5 iClk = ~iClk;

  accumulator_64b_pp_if #(.DW(64), .GW(16), .LW(8)) busA ();
  accumulator_64b_pp_if #(.DW(64), .GW(0),  .LW(8)) busB ();

  accumulator_64b_pp #(.DW(64), .GW(16), .LW(8)) dutA (
    .iClk (iClk), .iRst (iRst), .iEn (iEn), .iClr (iClr), .bus (busA)
  );
  accumulator_64b_pp #(.DW(64), .GW(0), .LW(8)) dutB (
    .iClk (iClk), .iRst (iRst), .iEn (iEn), .iClr (iClr), .bus (busB)
  );

  task automatic checkVal(input string tag, input logic [79:0] got, input logic [79:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    iRst = 1'b1; iEn = 1'b1; iClr = 1'b0;
    busA.iValid = 1'b0; busA.iData = '0; busA.iLen = '0; busA.iReady = 1'b0;
    busB.iValid = 1'b0; busB.iData = '0; busB.iLen = '0; busB.iReady = 1'b0;
    repeat (3) tick();
    iRst = 1'b0;
    checkVal("rst_valid", busA.oValid, 0);
    checkVal("rst_data",  busA.oData,  0);
    checkVal("rst_ovf",   busA.oOvf,   0);
    checkVal("rst_ready", busA.oReady, 1);

    // Group 1+2+3+4; iLen changed after the first beat must not matter
    busA.iValid = 1'b1; busA.iLen = 8'd4; busA.iData = 64'd1;
    tick();
    busA.iLen = 8'd9;
    busA.iData = 64'd2; tick();
    busA.iData = 64'd3; tick();
    checkVal("grp_not_done", busA.oValid, 0);
    busA.iData = 64'd4; tick();
    checkVal("grp_valid", busA.oValid, 1);
    checkVal("grp_data",  busA.oData,  10);
    checkVal("grp_ready", busA.oReady, 0);

    busA.iData = 64'd100;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkVal("bp_data", busA.oData, 10);
    end
    checkVal("bp_valid", busA.oValid, 1);
    busA.iValid = 1'b0; busA.iReady = 1'b1;
    tick();
    busA.iReady = 1'b0;
    checkVal("bp_rel_ready", busA.oReady, 1);
    checkVal("bp_rel_valid", busA.oValid, 0);

    // Clear after two of four beats, concurrent beat dropped
    busA.iValid = 1'b1; busA.iLen = 8'd4; busA.iData = 64'd9;
    tick(); tick();
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    checkVal("clr_data",  busA.oData,  0);
    checkVal("clr_ready", busA.oReady, 1);
    checkVal("clr_valid", busA.oValid, 0);
    busA.iData = 64'd5;
    tick(); tick();
    iEn = 1'b0; busA.iData = 64'd50;
    repeat (3) tick();
    checkVal("en_frozen", busA.oData, 10);
    iEn = 1'b1; busA.iData = 64'd5;
    tick(); tick();
    busA.iValid = 1'b0;
    checkVal("clr_grp_valid", busA.oValid, 1);
    checkVal("clr_grp_data",  busA.oData,  20);
    iEn = 1'b0; busA.iReady = 1'b1;
    tick();
    checkVal("en_hold_valid", busA.oValid, 1);
    iEn = 1'b1;
    tick();
    busA.iReady = 1'b0;
    checkVal("en_rel_valid", busA.oValid, 0);

    busA.iValid = 1'b1; busA.iLen = 8'd0; busA.iData = 64'd7;
    tick();
    busA.iValid = 1'b0;
    checkVal("len0_valid", busA.oValid, 1);
    checkVal("len0_data",  busA.oData,  7);
    busA.iReady = 1'b1; tick(); busA.iReady = 1'b0;

    busB.iValid = 1'b1; busB.iLen = 8'd2; busB.iData = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); tick();
    busB.iValid = 1'b0;
    checkVal("ovf_valid", busB.oValid, 1);
    checkVal("ovf_data",  busB.oData,  OvfSum);
    checkVal("ovf_flag",  busB.oOvf,   OvfFlag);
    busB.iReady = 1'b1; tick(); busB.iReady = 1'b0;

    // Asynchronous reset in the middle of a group discards it
    busA.iValid = 1'b1; busA.iLen = 8'd3; busA.iData = 64'd11;
    tick();
    busA.iValid = 1'b0;
    #2 iRst = 1'b1;
    #1;
    checkVal("mid_rst_data",  busA.oData,  0);
    checkVal("mid_rst_ready", busA.oReady, 1);
    checkVal("mid_rst_valid", busA.oValid, 0);
    tick();
    iRst = 1'b0;
    busA.iValid = 1'b1; busA.iLen = 8'd1; busA.iData = 64'd2;
    tick();
    busA.iValid = 1'b0;
    checkVal("post_rst_data", busA.oData, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
